// File: rtl/decode_scoreboard_if.sv
// Decode-stage handshake between the decode stage and the issue scoreboard.
// The decode stage (master) drives the instruction fields. The scoreboard
// (slave) returns stall/issue and its tracking state.
interface decode_scoreboard_if;
  logic        iIssueValid;
  logic [4:0]  iSrc0Addr;
  logic        iSrc0En;
  logic [4:0]  iSrc1Addr;
  logic        iSrc1En;
  logic [4:0]  iDstAddr;
  logic        iDstEn;
  logic [1:0]  iClass;
  logic        iLoadDone;
  logic        oStall;
  logic        oIssue;
  logic [31:0] oPending;
  logic        oMduBusy;
  logic        oFpuBusy;
  logic        oLoadBusy;

  modport master (
    output iIssueValid, iSrc0Addr, iSrc0En, iSrc1Addr, iSrc1En,
           iDstAddr, iDstEn, iClass, iLoadDone,
    input  oStall, oIssue, oPending, oMduBusy, oFpuBusy, oLoadBusy
  );

  modport slave (
    input  iIssueValid, iSrc0Addr, iSrc0En, iSrc1Addr, iSrc1En,
           iDstAddr, iDstEn, iClass, iLoadDone,
    output oStall, oIssue, oPending, oMduBusy, oFpuBusy, oLoadBusy
  );
endinterface

// File: rtl/decode_scoreboard.sv
// Issue scoreboard beside decode. It tracks in-flight destinations of the
// MDU, FPU and load unit, and stalls decode on RAW, WAW or busy-unit hazards.
// MDU/FPU results retire by per-register countdown. A load retires on
// iLoadDone. Register 0 is never tracked.
module decode_scoreboard #(
  parameter int MDU_LAT = 4,
  parameter int FPU_LAT = 6
) (
  input logic                iClk,
  input logic                iRst,
  decode_scoreboard_if.slave bus
);

  localparam logic [1:0] CLS_LOAD = 2'd1;
  localparam logic [1:0] CLS_MDU  = 2'd2;
  localparam logic [1:0] CLS_FPU  = 2'd3;
  localparam logic [2:0] MDU_LAT_C = 3'(MDU_LAT);
  localparam logic [2:0] FPU_LAT_C = 3'(FPU_LAT);

  logic [31:0] pending_q, pending_d;
  logic [2:0]  cnt_q [32];
  logic [2:0]  cnt_d [32];
  logic [2:0]  mdu_cnt_q, mdu_cnt_d;
  logic [2:0]  fpu_cnt_q, fpu_cnt_d;
  logic        load_busy_q, load_busy_d;
  logic [4:0]  load_dst_q, load_dst_d;

  logic        stall;
  logic        issue;
  logic        mdu_busy;
  logic        fpu_busy;
  logic        issue_load;
  logic [2:0]  issue_lat;

  assign mdu_busy   = (mdu_cnt_q != 3'd0);
  assign fpu_busy   = (fpu_cnt_q != 3'd0);
  assign issue      = bus.iIssueValid && !stall;
  assign issue_load = issue && (bus.iClass == CLS_LOAD);
  assign issue_lat  = (bus.iClass == CLS_FPU) ? FPU_LAT_C : MDU_LAT_C;

  // Hazard detection. pending_q[0] is held at 0, so address 0 never matches.
  always_comb begin
    stall = 1'b0;
    if (bus.iIssueValid) begin
      stall = (bus.iSrc0En && pending_q[bus.iSrc0Addr])
            | (bus.iSrc1En && pending_q[bus.iSrc1Addr])
            | (bus.iDstEn  && pending_q[bus.iDstAddr])
            | ((bus.iClass == CLS_MDU)  && mdu_busy)
            | ((bus.iClass == CLS_FPU)  && fpu_busy)
            | ((bus.iClass == CLS_LOAD) && load_busy_q);
    end
  end

  // Per-register tracking. A set on issue has priority over clears. A
  // same-register clear on the same edge cannot happen, because the pending
  // bit stalls that issue.
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign pending_d[gi] = 1'b0;
        assign cnt_d[gi]     = 3'd0;
      end else begin : g_track
        logic hit;
        logic timed_set;
        logic load_set;
        logic load_clr;
        assign hit       = issue && bus.iDstEn && (bus.iDstAddr == 5'(gi));
        assign timed_set = hit && bus.iClass[1];
        assign load_set  = hit && (bus.iClass == CLS_LOAD);
        assign load_clr  = bus.iLoadDone && load_busy_q && (load_dst_q == 5'(gi));
        assign cnt_d[gi] = timed_set ? issue_lat :
                           (cnt_q[gi] != 3'd0) ? cnt_q[gi] - 3'd1 : 3'd0;
        assign pending_d[gi] = (timed_set || load_set) ? 1'b1 :
                               ((cnt_q[gi] == 3'd1) || load_clr) ? 1'b0 :
                               pending_q[gi];
      end
    end
  endgenerate

  // Unit occupancy. A load issued with no destination records r0, so its
  // completion clears nothing.
  always_comb begin
    mdu_cnt_d = (mdu_cnt_q != 3'd0) ? mdu_cnt_q - 3'd1 : 3'd0;
    fpu_cnt_d = (fpu_cnt_q != 3'd0) ? fpu_cnt_q - 3'd1 : 3'd0;
    if (issue && (bus.iClass == CLS_MDU)) mdu_cnt_d = MDU_LAT_C;
    if (issue && (bus.iClass == CLS_FPU)) fpu_cnt_d = FPU_LAT_C;
    load_busy_d = load_busy_q;
    load_dst_d  = load_dst_q;
    if (issue_load) begin
      load_busy_d = 1'b1;
      load_dst_d  = bus.iDstEn ? bus.iDstAddr : 5'd0;
    end else if (bus.iLoadDone) begin
      load_busy_d = 1'b0;
    end
  end

  // State registers. Reset discards everything in flight.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pending_q   <= '0;
      mdu_cnt_q   <= '0;
      fpu_cnt_q   <= '0;
      load_busy_q <= 1'b0;
      load_dst_q  <= '0;
      for (int r = 0; r < 32; r++) cnt_q[r] <= '0;
    end else begin
      pending_q   <= pending_d;
      mdu_cnt_q   <= mdu_cnt_d;
      fpu_cnt_q   <= fpu_cnt_d;
      load_busy_q <= load_busy_d;
      load_dst_q  <= load_dst_d;
      for (int r = 0; r < 32; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign bus.oStall    = stall;
  assign bus.oIssue    = issue;
  assign bus.oPending  = pending_q;
  assign bus.oMduBusy  = mdu_busy;
  assign bus.oFpuBusy  = fpu_busy;
  assign bus.oLoadBusy = load_busy_q;

endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
- Issue-control block beside the instruction decode stage. Tracks destination registers with results still in flight from multi-cycle units: MDU, FPU and loads.
- Raises a stall when the instruction in decode has a hazard. Hazards covered: RAW on a source, WAW on the destination, or a structural conflict on a busy non-pipelined unit.
- Sequences register-file use so that decode never reads a stale operand. Single clock domain.

Parameters:
- MDU_LAT, 4, cycles from MDU issue to result written (1..7)
- FPU_LAT, 6, cycles from FPU issue to result written (1..7)

Ports:
- iClk  in  1  clock
- iRst  in  1  synchronous active-high reset
- iIssueValid  in  1  decode holds a valid instruction
- iSrc0Addr  in  5  source 0 register address
- iSrc0En  in  1  source 0 is read
- iSrc1Addr  in  5  source 1 register address
- iSrc1En  in  1  source 1 is read
- iDstAddr  in  5  destination register address
- iDstEn  in  1  instruction writes iDstAddr
- iClass  in  2  0=ALU/other, 1=load, 2=MDU, 3=FPU
- iLoadDone  in  1  outstanding load has written back this cycle
- oStall  out  1  hold decode; the instruction is not issued
- oIssue  out  1  instruction accepted this cycle
- oPending  out  32  per-register in-flight mask; bit 0 is always 0
- oMduBusy  out  1  MDU occupied
- oFpuBusy  out  1  FPU occupied
- oLoadBusy  out  1  a load is outstanding

Behaviour:
- The design is single-clock and uses synchronous active-high reset only.
- Reset clears:
  - all pending bits and per-register 3-bit countdowns
  - MDU and FPU busy counters
  - the load-outstanding flag and the load destination register
- After reset all outputs are 0.
- Reset asserted mid-operation discards every in-flight entry. No late clear is produced after reset.
- Register 0 is never tracked: bit 0 of the pending mask is never set, and a hazard check on address 0 never matches.
- oStall is combinational from current state and the decode inputs. It is 0 when iIssueValid=0. Otherwise it is the OR of:
  - iSrc0En and pending[iSrc0Addr]
  - iSrc1En and pending[iSrc1Addr]
  - iDstEn and pending[iDstAddr]
  - iClass=2 and oMduBusy
  - iClass=3 and oFpuBusy
  - iClass=1 and oLoadBusy
- oIssue = iIssueValid and not oStall (combinational).
- When oIssue=1 at a clock edge:
  - MDU (class 2): the MDU busy counter loads MDU_LAT. If iDstEn, pending[dst] is set and its countdown loads MDU_LAT.
  - FPU (class 3): same as MDU, using FPU_LAT.
  - Load (class 1): the load-outstanding flag is set. If iDstEn, pending[dst] is set and the load destination is recorded. Loads have no countdown.
  - ALU (class 0): no state change. Its results are forwarded.
- Each cycle, every nonzero countdown decrements by 1. The transition from 1 to 0 clears that register's pending bit on the same edge.
- With MDU_LAT=4, a dependent instruction is stalled for the 4 cycles after issue. It issues on the 5th cycle.
- The MDU and FPU busy counters decrement in the same way. Each busy output is 1 while its counter is nonzero.
- iLoadDone clears the load-outstanding flag and pending[load destination] on the next edge. iLoadDone with no outstanding load is ignored.
- Same-edge events:
  - iLoadDone and a new load issue cannot coincide: the issue is stalled by the flag still being set.
  - A countdown expiry and a WAW issue to the same register cannot coincide: the pending bit stalls the issue.
  - An expiry on register A and an issue to register B on the same edge both take effect.
- MDU and FPU may be in flight simultaneously, along with one load.
- oPending reflects registered state only. It does not include the issue happening this cycle.

Test Plan:
- Reset, then MDU issue with dst=r5 (MDU_LAT=4). Then valid ADD with src0=r5.
  - Required: oStall=1 for exactly 4 cycles, oIssue=1 on cycle 5.
  - oPending[5] is 1 for cycles 1-4 and 0 after.
- FPU issue with dst=r7, then an FPU op with dst=r9 the next cycle.
  - Required: structural stall, oFpuBusy=1 for 6 cycles.
  - Second FPU op issues on cycle 7.
- Load with dst=r3 and iLoadDone held low for 10 cycles, consumer reads r3.
  - Required: stall for all 10 cycles.
  - After iLoadDone pulses, oPending[3]=0 and the consumer issues the following cycle.
- MDU issue with dst=r0, then a consumer of r0.
  - Required: oPending=0, no stall.
  - oMduBusy=1 for 4 cycles.
- WAW case: MDU issue with dst=r4, then an ALU op writing r4 with no source reads.
  - Required: stall until r4 clears.
  - An independent ALU op (r1 to r2) issues immediately.
- Assert iRst while MDU, FPU and a load are all in flight.
  - Required: next cycle oPending=0, all busy outputs 0, oStall=0 for any instruction.
  - A later iLoadDone causes no change.
